// File: rtl/serial_collect_pkg.sv
// Shared definitions for the serial word collector: FSM state encoding,
// default word width and the bit-counter width helper.
package serial_collect_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Smallest w with 2**w >= width; legal widths stop at 32.
    function automatic int calc_cnt_w(input int width);
        int w;
        w = 0;
        for (int i = 0; i < 6; i++) begin
            if ((1 << i) < width) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_out_reg.sv
// Output holding register with valid/ready handshake and overrun detection.
// Optional word_parity output when SERIAL_COLLECT_PARITY_EN is defined.
module serial_out_reg
    import serial_collect_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             t_clk,
    input  logic             rn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
`ifdef SERIAL_COLLECT_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    // A completed word either replaces a consumed/empty slot or is dropped
    // while the held word stays put.
    always_ff @(posedge t_clk or negedge rn) begin
        if (!rn) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                if (!word_valid || word_ready) begin
                    word_out   <= load_data;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_COLLECT_PARITY_EN
    always_ff @(posedge t_clk or negedge rn) begin
        if (!rn) begin
            word_parity <= 1'b0;
        end else if (load && (!word_valid || word_ready)) begin
            word_parity <= ^load_data;
        end
    end
`endif

endmodule

// File: rtl/serial_word_collector.sv
// LSB-first deserializer feeding a valid/ready word interface, with a
// per-word clear pulse upstream. Optional parity: SERIAL_COLLECT_PARITY_EN.
module serial_word_collector
    import serial_collect_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = calc_cnt_w(WIDTH)
) (
    input  logic             t_clk,
    input  logic             rn,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             comp_clr,
    output logic             overrun,
    output logic             frame_err
`ifdef SERIAL_COLLECT_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sr, sr_next, sr_shifted;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             word_done, word_done_next;
    logic             frame_err_next;

    assign sr_shifted = {bit_in, sr[WIDTH-1:1]};

    // word_done marks the cycle in which sr holds a full word; the output
    // register and comp_clr both act on it one edge later.
    always_ff @(posedge t_clk or negedge rn) begin
        if (!rn) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            word_done <= 1'b0;
            comp_clr  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            cnt       <= cnt_next;
            word_done <= word_done_next;
            comp_clr  <= word_done;
            frame_err <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        sr_next        = sr;
        cnt_next       = cnt;
        word_done_next = 1'b0;
        frame_err_next = frame_err;
        case (state)
            IDLE: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        sr_next    = sr_shifted;
                        cnt_next   = CNT_W'(1);
                        state_next = SHIFT;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    sr_next = sr_shifted;
                    if (frame_start) begin
                        // Abandon the partial word; this bit restarts a new one.
                        frame_err_next = 1'b1;
                        cnt_next       = CNT_W'(1);
                    end else if (cnt == LAST_BIT) begin
                        cnt_next       = '0;
                        state_next     = IDLE;
                        word_done_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    serial_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .t_clk      (t_clk),
        .rn         (rn),
        .load       (word_done),
        .load_data  (sr),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun)
`ifdef SERIAL_COLLECT_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector (WIDTH=8).
// Parity checks are included when SERIAL_COLLECT_PARITY_EN is defined.
module tb_serial_word_collector;

    localparam int WIDTH = 8;

    logic             t_clk = 1'b0;
    logic             rn = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             comp_clr;
    logic             overrun;
    logic             frame_err;
`ifdef SERIAL_COLLECT_PARITY_EN
    logic             word_parity;
`endif

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int start_cyc;

    serial_word_collector #(
        .WIDTH(WIDTH)
    ) dut (
        .t_clk      (t_clk),
        .rn         (rn),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .comp_clr   (comp_clr),
        .overrun    (overrun),
        .frame_err  (frame_err)
`ifdef SERIAL_COLLECT_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

    always #5 t_clk = ~t_clk;

    always @(posedge t_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge t_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic b, input logic v, input logic fs);
        bit_in      = b;
        bit_valid   = v;
        frame_start = fs;
        step();
    endtask

    // Sends the low n bits of w LSB first, inserting stall_len idle cycles
    // before bit index stall_at.
    task automatic sendBits(input logic [7:0] w, input int n, input int stall_at,
                            input int stall_len);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                repeat (stall_len) applyStimulus(1'b0, 1'b0, 1'b0);
            end
            applyStimulus(w[i], 1'b1, i == 0);
        end
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic doReset();
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        rn          = 1'b0;
        step();
        rn = 1'b1;
    endtask

    initial begin
        // Asynchronous reset assertion away from any clock edge
        #2 rn = 1'b0;
        #1;
        checkOutput("rst_word_out", word_out, 0);
        checkOutput("rst_valid", word_valid, 0);
        checkOutput("rst_comp_clr", comp_clr, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        step();
        rn = 1'b1;
        word_ready = 1'b1;

        $display("[TB] basic word 0xFA");
        start_cyc = cyc;
        sendBits(8'hFA, 8, -1, 0);
        checkOutput("t1_valid_early", word_valid, 0);
        checkOutput("t1_clr_early", comp_clr, 0);
        step();
        checkOutput("t1_valid", word_valid, 1);
        checkOutput("t1_word", word_out, 32'hFA);
        checkOutput("t1_clr", comp_clr, 1);
        checkOutput("t1_latency", cyc - start_cyc, 9);
`ifdef SERIAL_COLLECT_PARITY_EN
        checkOutput("t1_parity", word_parity, 0);
`endif
        step();
        checkOutput("t1_clr_off", comp_clr, 0);
        checkOutput("t1_valid_drop", word_valid, 0);

        $display("[TB] stalled word 0xFA");
        start_cyc = cyc;
        sendBits(8'hFA, 8, 4, 3);
        checkOutput("t2_valid_early", word_valid, 0);
        step();
        checkOutput("t2_valid", word_valid, 1);
        checkOutput("t2_word", word_out, 32'hFA);
        checkOutput("t2_latency", cyc - start_cyc, 12);
        step();

        $display("[TB] overrun with word_ready low");
        word_ready = 1'b0;
        sendBits(8'hFA, 8, -1, 0);
        step();
        checkOutput("t3_valid", word_valid, 1);
        checkOutput("t3_word", word_out, 32'hFA);
        sendBits(8'h01, 8, -1, 0);
        checkOutput("t3_no_overrun_yet", overrun, 0);
        step();
        checkOutput("t3_clr", comp_clr, 1);
        checkOutput("t3_overrun", overrun, 1);
        checkOutput("t3_word_kept", word_out, 32'hFA);
        step();
        checkOutput("t3_clr_off", comp_clr, 0);
        checkOutput("t3_still_valid", word_valid, 1);
        word_ready = 1'b1;
        step();
        checkOutput("t3_valid_drop", word_valid, 0);
        checkOutput("t3_overrun_sticky", overrun, 1);

        $display("[TB] frame_start mid-word");
        doReset();
        sendBits(8'hFA, 3, -1, 0);
        checkOutput("t4_frame_err_pre", frame_err, 0);
        sendBits(8'h55, 8, -1, 0);
        checkOutput("t4_frame_err", frame_err, 1);
        checkOutput("t4_valid_early", word_valid, 0);
        step();
        checkOutput("t4_valid", word_valid, 1);
        checkOutput("t4_word", word_out, 32'h55);
`ifdef SERIAL_COLLECT_PARITY_EN
        checkOutput("t4_parity", word_parity, 0);
`endif

        $display("[TB] stray bit in IDLE");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        checkOutput("t5_frame_err", frame_err, 1);
        repeat (10) step();
        checkOutput("t5_valid", word_valid, 0);
        checkOutput("t5_clr", comp_clr, 0);
        checkOutput("t5_word", word_out, 0);

        $display("[TB] reset mid-word");
        doReset();
        word_ready = 1'b0;
        sendBits(8'hFA, 8, -1, 0);
        step();
        checkOutput("t6_held_valid", word_valid, 1);
        checkOutput("t6_overrun_clear", overrun, 0);
        checkOutput("t6_frame_err_clear", frame_err, 0);
        sendBits(8'hFF, 5, -1, 0);
        #2 rn = 1'b0;
        #1;
        checkOutput("t6_rst_word", word_out, 0);
        checkOutput("t6_rst_valid", word_valid, 0);
        step();
        rn = 1'b1;
        word_ready = 1'b1;
        sendBits(8'h80, 8, -1, 0);
        checkOutput("t6_valid_early", word_valid, 0);
        step();
        checkOutput("t6_valid", word_valid, 1);
        checkOutput("t6_word", word_out, 32'h80);
        checkOutput("t6_overrun", overrun, 0);
        checkOutput("t6_frame_err", frame_err, 0);
        checkOutput("t6_clr", comp_clr, 1);
`ifdef SERIAL_COLLECT_PARITY_EN
        checkOutput("t6_parity", word_parity, 1);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Deserializer sitting directly downstream of the bit-serial two's-complement stage. It consumes that stage's LSB-first output bit stream and assembles it into parallel words.
- Each completed word is presented on a valid/ready interface.
- It also issues the per-word clear pulse that re-arms the upstream complementer between words.

Parameters:
- WIDTH, 8, bits per serial word. Legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- t_clk  in  1  single clock; all state updates on the rising edge.
- rn  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial data (upstream y), LSB first.
- bit_valid  in  1  bit_in is sampled this cycle.
- frame_start  in  1  qualifies bit_valid: this bit is bit 0 of a new word.
- word_out  out  WIDTH  assembled word, bit 0 = first serial bit.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
- comp_clr  out  1  one-cycle registered pulse, high-active, to upstream complementer r.
- overrun  out  1  sticky: a completed word was dropped.
- frame_err  out  1  sticky: framing violation.

Behaviour:
- Reset (rn low, asynchronous):
  - word_out=0, word_valid=0, comp_clr=0, overrun=0, frame_err=0.
  - Shift register=0, counter=0, state=IDLE.
  - Reset mid-word discards the partial word.
- States: IDLE (no word in progress) and SHIFT (collecting bits 1..WIDTH-1).
- IDLE:
  - bit_valid && frame_start: sr <= {bit_in, sr[WIDTH-1:1]}, cnt <= 1, go to SHIFT.
  - bit_valid && !frame_start: bit dropped, frame_err <= 1, stay in IDLE.
- SHIFT:
  - bit_valid && !frame_start: shift the bit in, cnt++.
  - When the accepted bit has cnt==WIDTH-1: the word is complete, cnt <= 0, go to IDLE.
  - bit_valid && frame_start: partial word abandoned, frame_err <= 1. The bit is taken as bit 0 of a new word (cnt <= 1, stay in SHIFT).
  - bit_valid low: stall; no shift, no count change.
- Bit order:
  - Right shift with insertion at the MSB. After WIDTH accepted bits, the first bit is at word_out[0].
- Completion (cycle after the last bit is sampled, latency 1):
  - Output register empty, or word_ready high this cycle: word_out <= assembled word, word_valid <= 1.
  - Output register holds an unconsumed word and word_ready is low: new word dropped, old word_out kept, overrun <= 1.
  - comp_clr is high for exactly one cycle in the same cycle word_valid is updated, whether the word was accepted or dropped.
- Handshake:
  - Transfer occurs when word_valid && word_ready.
  - word_valid falls the next cycle unless a new word loads in that same cycle; then it stays 1 and word_out updates.
  - word_out is stable while word_valid && !word_ready.
- The shift register is independent of the output register, so a new word can be collected while the previous one is held.
- overrun and frame_err clear only on reset.

Optional Feature:
- Macro: SERIAL_COLLECT_PARITY_EN.
- Defined: adds output port word_parity (1 bit) = XOR of all bits of word_out.
  - Registered and loaded together with word_out.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_collect_pkg:
  - State enum (IDLE, SHIFT).
  - Default WIDTH constant.
  - Function computing CNT_W.
- Sub-module serial_out_reg:
  - Holds the output register, the valid/ready handshake, the overrun detect and the optional parity.
  - Inputs: load strobe and data from the shift/FSM top.

Test Plan:
- Reset release, WIDTH=8: 0x06 complemented gives serial 0,1,0,1,1,1,1,1 with frame_start on the first bit and word_ready=1 -> word_out=0xFA, word_valid high 1 cycle after the 8th bit, comp_clr single pulse.
- Same word with bit_valid low for 3 cycles mid-word -> same 0xFA, completion delayed by exactly 3 cycles.
- word_ready=0: send 0xFA then 0x01 -> word_out stays 0xFA, overrun=1, second comp_clr still pulses; raise word_ready -> word_valid drops next cycle.
- frame_start asserted on the 4th bit of a word, followed by 7 more bits of 0x55 -> frame_err=1, word_out=0x55 (with 0x55's first bit taken as the new bit 0).
- bit_valid without frame_start in IDLE -> bit ignored, frame_err=1, no word_valid.
- Assert rn low at bit 5, release, send 0x80 -> word_out=0x80, flags clear until the event. With SERIAL_COLLECT_PARITY_EN: 0xFA -> word_parity=0; 0x80 -> word_parity=1.
